// File: rtl/bist_transmitter_if.sv
// Channel-side bundle of the BIST pattern source: run control, mission-mode
// data in, channel data out, and the receiver reset/status strobes.
interface bist_transmitter_if #(
  parameter int TEST_CHANNELS = 70
);
  logic                     start;
  logic [TEST_CHANNELS-1:0] functional_channels;
  logic [TEST_CHANNELS-1:0] output_channels;
  logic                     rx_reset;
  logic                     busy;
  logic                     done;

  // The transmitter itself.
  modport master (
    input  start,
    input  functional_channels,
    output output_channels,
    output rx_reset,
    output busy,
    output done
  );

  // Whatever controls the run and consumes the channel data.
  modport slave (
    output start,
    output functional_channels,
    input  output_channels,
    input  rx_reset,
    input  busy,
    input  done
  );
endinterface

// File: rtl/bist_transmitter.sv
// BIST pattern source: replays the receiver's expected-word recurrence onto
// the channel bus and sequences the receiver's reset so that comparison
// starts exactly when the first pattern word arrives through the pipe.
// Outside a run the functional channels pass straight through.
module bist_transmitter #(
  parameter int          TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int          TEST_CASES    = 1000,
  parameter int          LATENCY       = 2
) (
  input  logic               clk,
  input  logic               reset,
  bist_transmitter_if.master bus
);

  // A zero-latency pipe still needs a 1-bit counter to keep widths legal.
  localparam int               LAT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX   = LAT_W'(LATENCY);
  localparam logic [31:0]      LAST_CNT  = 32'(TEST_CASES - 1);
  // Galois (right-shift) form, same taps as the receiver's lfsr32.
  localparam logic [31:0]      LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q;
  logic [TEST_CHANNELS-1:0] pattern_q;
  logic [TEST_CHANNELS-1:0] pattern_d;
  logic [31:0]              tx_cnt_q;
  logic [31:0]              lfsr_q;
  logic [31:0]              lfsr_d;
  logic [LAT_W-1:0]         lat_cnt_q;
  logic [LAT_W-1:0]         lat_cnt_d;
  logic                     rx_reset_q;
  logic                     busy_q;
  logic                     done_q;

  assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign lat_cnt_d = (lat_cnt_q < LAT_MAX) ? lat_cnt_q + 1'b1 : lat_cnt_q;

  // Next pattern word: shift the previous word up by 32 and append rng_out,
  // keeping only the low TEST_CHANNELS bits.
  if (TEST_CHANNELS > 32) begin : g_pat_wide
    assign pattern_d = {pattern_q[TEST_CHANNELS-33:0], lfsr_q};
  end else if (TEST_CHANNELS == 32) begin : g_pat_word
    assign pattern_d = lfsr_q;
  end else begin : g_pat_narrow
    assign pattern_d = lfsr_q[TEST_CHANNELS-1:0];
  end

  // Pattern generator: parked at SEED outside SEND so SEND cycle 0 emits SEED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else if (state_q != S_SEND) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Run sequencer with registered rx_reset/busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      tx_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      rx_reset_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_ARM;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            rx_reset_q <= 1'b1;
          end
        end
        S_ARM: begin
          pattern_q  <= '0;
          tx_cnt_q   <= '0;
          lat_cnt_q  <= '0;
          state_q    <= S_SEND;
          // SEND cycle 0 already releases the receiver when there is no pipe.
          rx_reset_q <= (LAT_MAX != '0);
        end
        S_SEND: begin
          pattern_q <= pattern_d;
          if (tx_cnt_q == LAST_CNT) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rx_reset_q <= 1'b0;
          end else begin
            tx_cnt_q   <= tx_cnt_q + 32'd1;
            lat_cnt_q  <= lat_cnt_d;
            rx_reset_q <= (lat_cnt_d < LAT_MAX);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.output_channels = (state_q == S_SEND) ? pattern_q : bus.functional_channels;
  assign bus.rx_reset        = rx_reset_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_bist_transmitter.sv
// Bench for bist_transmitter: two instances (70-bit with a 2-stage pipe, and
// 16-bit with no pipe) driven by random start/reset/functional data and
// checked every cycle against a run-position model.
module tb_bist_transmitter;
  localparam int          TCA  = 70;
  localparam int          NA   = 24;
  localparam int          LA   = 2;
  localparam int          TCB  = 16;
  localparam int          NB   = 4;
  localparam int          LB   = 0;
  localparam logic [31:0] SEED = 32'hdeadbeef;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  // Run position: -1 idle, 1 ARM, 2..N+1 SEND word pos-2, N+2 DONE.
  int   pa_pos = -1;
  int   pb_pos = -1;
  logic [TCA-1:0] pa [NA];
  logic [TCB-1:0] pb [NB];

  always #5 clk = ~clk;

  bist_transmitter_if #(.TEST_CHANNELS(TCA)) ifa ();
  bist_transmitter_if #(.TEST_CHANNELS(TCB)) ifb ();

  bist_transmitter #(.TEST_CHANNELS(TCA), .SEED(SEED), .TEST_CASES(NA), .LATENCY(LA)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  bist_transmitter #(.TEST_CHANNELS(TCB), .SEED(SEED), .TEST_CASES(NB), .LATENCY(LB)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic int next_pos(input int p, input logic s, input int n);
    if ((p < 0 || p >= n + 2) && s) return 1;
    if (p < 0) return -1;
    if (p >= n + 2) return n + 2;
    return p + 1;
  endfunction

  function automatic logic [TCA-1:0] word_a(input int p);
    if (p >= 2 && p <= NA + 1) return pa[p-2];
    return '0;
  endfunction

  function automatic logic [TCB-1:0] word_b(input int p);
    if (p >= 2 && p <= NB + 1) return pb[p-2];
    return '0;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Expected outputs of one instance derived from its run position.
  task automatic cmp(input string tag, input int pos, input int n, input int lat,
                     input logic [127:0] out, input logic [127:0] func, input logic [127:0] word,
                     input logic rx, input logic bsy, input logic dn);
    logic [127:0] eo;
    logic er, eb, ed;
    if (pos < 0) begin
      eo = func; er = 1'b1; eb = 1'b0; ed = 1'b0;
    end else if (pos == 1) begin
      eo = func; er = 1'b1; eb = 1'b1; ed = 1'b0;
    end else if (pos <= n + 1) begin
      eo = word; er = ((pos - 2) < lat); eb = 1'b1; ed = 1'b0;
    end else begin
      eo = func; er = 1'b0; eb = 1'b0; ed = 1'b1;
    end
    chk({tag, "_out"}, out, eo);
    chk({tag, "_rx_reset"}, {127'd0, rx}, {127'd0, er});
    chk({tag, "_busy"}, {127'd0, bsy}, {127'd0, eb});
    chk({tag, "_done"}, {127'd0, dn}, {127'd0, ed});
  endtask

  task automatic compare();
    cmp("a", pa_pos, NA, LA, 128'(ifa.output_channels), 128'(ifa.functional_channels),
        128'(word_a(pa_pos)), ifa.rx_reset, ifa.busy, ifa.done);
    cmp("b", pb_pos, NB, LB, 128'(ifb.output_channels), 128'(ifb.functional_channels),
        128'(word_b(pb_pos)), ifb.rx_reset, ifb.busy, ifb.done);
    if (pa_pos == 2) chk("a_P0_lit", 128'(ifa.output_channels), 128'd0);
    if (pa_pos == 3) chk("a_P1_lit", 128'(ifa.output_channels), 128'h00deadbeef);
    if (pa_pos == 4) chk("a_P2_lit", 128'(ifa.output_channels), 128'hdeadbeefef76df74);
    if (pb_pos == 3) chk("b_P1_lit", 128'(ifb.output_channels), 128'hbeef);
    if (pb_pos == 4) chk("b_P2_lit", 128'(ifb.output_channels), 128'hdf74);
    if (pb_pos == 5) chk("b_P3_lit", 128'(ifb.output_channels), 128'h6fba);
  endtask

  // One clock: check outputs on the falling edge, then drive new inputs.
  task automatic cyc(input logic sa, input logic sb, input logic rst_v, input bit rnd);
    logic [95:0] w;
    @(negedge clk);
    compare();
    ifa.start = sa;
    ifb.start = sb;
    if (rnd) begin
      w = {$urandom, $urandom, $urandom};
      ifa.functional_channels = w[TCA-1:0];
      ifb.functional_channels = w[TCB+39:40];
    end
    if (reset && !rst_v) begin
      reset = 1'b0;
      #1;
      chk("rst_a_out", 128'(ifa.output_channels), 128'(ifa.functional_channels));
      chk("rst_a_rx_reset", {127'd0, ifa.rx_reset}, 128'd1);
      chk("rst_a_busy", {127'd0, ifa.busy}, 128'd0);
      chk("rst_b_out", 128'(ifb.output_channels), 128'(ifb.functional_channels));
      chk("rst_b_rx_reset", {127'd0, ifb.rx_reset}, 128'd1);
      chk("rst_b_done", {127'd0, ifb.done}, 128'd0);
    end else begin
      reset = rst_v;
    end
  endtask

  // Model advance on the active edge.
  always @(posedge clk) begin
    if (!reset) begin
      pa_pos <= -1;
      pb_pos <= -1;
    end else begin
      pa_pos <= next_pos(pa_pos, ifa.start, NA);
      pb_pos <= next_pos(pb_pos, ifb.start, NB);
    end
  end

  initial begin
    logic [159:0] acc;
    logic [31:0]  r;
    bit           hit;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifa.functional_channels = 70'h15A5;
    ifb.functional_channels = 16'h15A5;

    // Word k is the last k rng outputs concatenated, newest in the LSBs.
    acc = '0;
    r   = SEED;
    for (int k = 0; k < NA; k++) begin
      pa[k] = acc[TCA-1:0];
      if (k < NB) pb[k] = acc[TCB-1:0];
      acc = {acc[127:0], r};
      r   = lfsr_step(r);
    end
    chk("model_P2", 128'(pa[2]), 128'hdeadbeefef76df74);
    chk("model_b_P3", 128'(pb[3]), 128'h6fba);

    // Reset held, then idle passthrough.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle_lit_a", 128'(ifa.output_channels), 128'h15A5);
    chk("idle_lit_b", 128'(ifb.output_channels), 128'h15A5);
    chk("idle_rx_reset", {127'd0, ifa.rx_reset}, 128'd1);

    // Single run each.
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // start held high: retriggers from DONE every pass.
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Random start pulses and occasional resets.
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 299) != 0), 1'b1);

    // Reset in SEND cycle 10 of instance a, then a clean rerun.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      if (pa_pos == 11) hit = 1'b1;
    end
    chk("midrun_reach", 128'(pa_pos), 128'd11);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
